prn_delay_line_ctrl: RTL and testbench
======================================

// Module: prn_delay_line_ctrl
// PURPOSE
//  Parametrised delay-line controller for the PRN-based CDR loop. Delays a WIDTH-bit
//  sample stream through a DEPTH-stage tapped delay line; the phase detector steers the
//  tap via shift_right/shift_left. Adds saturation flags, rate-limited tap moves and
//  optional lock detection. Sits between the recovered-data path and the phase detector.
// PARAMETERS
//  WIDTH     1   bits per sample (din/dout width)
//  DEPTH     16  delay stages (taps 0..DEPTH-1), >=2
//  INIT_TAP  8   tap loaded on reset, < DEPTH
//  STEP_GAP  4   quiet cycles enforced after each tap move (0 = move every cycle)
//  LOCK_CNT  32  consecutive no-move cycles before locked=1 (only with DLC_LOCK_DET_EN)
// PORTS
//  clk          in   1              system clock, all logic on rising edge
//  rst          in   1              asynchronous, active-high reset
//  din          in   WIDTH          input sample, captured every cycle
//  shift_right  in   1              request: increase delay by one tap
//  shift_left   in   1              request: decrease delay by one tap
//  dout         out  WIDTH          registered tapped output
//  tap          out  TAP_W          current tap, TAP_W = clog2(DEPTH)
//  at_max       out  1              tap == DEPTH-1 (combinational from tap)
//  at_min       out  1              tap == 0 (combinational from tap)
//  locked       out  1              lock indicator (only with DLC_LOCK_DET_EN)
// BEHAVIOUR
//  - Reset (async, rst=1): all stages 0, dout 0, tap INIT_TAP, gap counter 0, quiet
//    counter 0, locked 0. Flags follow tap immediately.
//  - Datapath: stage[0] <= din; stage[i] <= stage[i-1]; dout <= stage[tap].
//    Latency din->dout = tap+2 cycles.
//  - Command decode per cycle: RIGHT = sr & ~sl; LEFT = sl & ~sr; both or neither = HOLD.
//  - Move accepted only when gap==0 and not saturated in that direction:
//    RIGHT & tap<DEPTH-1 -> tap+1; LEFT & tap>0 -> tap-1. No wrap-around ever.
//  - Accepted move: tap updates at that edge, gap loads STEP_GAP; new tap selects dout
//    from the next edge. Held request moves every STEP_GAP+1 cycles.
//  - gap>0: decrements by 1 per cycle regardless of requests; requests ignored (not queued).
//  - Blocked requests (saturated, HOLD, gap>0) leave tap and gap unchanged (gap still
//    decrements) and do not count as moves.
//  - Reset asserted mid-operation: immediate return to reset state; delay-line contents lost.
// CONFIGURATION
//  DLC_LOCK_DET_EN defined: quiet counter increments each cycle without an accepted move,
//    saturates at LOCK_CNT; locked=1 while counter==LOCK_CNT; an accepted move clears
//    counter and drops locked on the same edge.
//  Undefined: no quiet counter; locked port tied 0 (port retained).
// STRUCTURE
//  - Shared package prn_cdr_pkg: TAP_W clog2 function, shift_cmd_t enum {CMD_HOLD,
//    CMD_RIGHT, CMD_LEFT}, reset-value constants.
//  - One sub-module dlc_tap_ctrl: command decode, tap pointer, gap counter, lock counter.
//    Top holds the delay line and output mux.
// TESTING (DEPTH=16, INIT_TAP=8, STEP_GAP=4, LOCK_CNT=32, WIDTH=1)
//  1 Release rst at 20ns, din=0001100001100101..., no shifts -> tap=8, dout = din delayed 10 cycles.
//  2 shift_right held 60 cycles -> tap 9,10,...,15 one step per 5 cycles; at_max=1, tap stays 15.
//  3 shift_right=shift_left=1 for 20 cycles -> tap, gap behaviour as HOLD; tap unchanged.
//  4 From tap=0 (after shift_left runs) pulse shift_left -> tap stays 0, at_min=1, no gap load.
//  5 DLC_LOCK_DET_EN: 32 quiet cycles -> locked=1; one accepted shift_left -> locked=0 same edge.
//  6 Assert rst mid-shift (tap=12, gap=3) -> tap=8, dout=0, gap=0, locked=0 without waiting for clk.

Source files
------------

// File: rtl/prn_cdr_pkg.sv
// prn_cdr_pkg: shared types, reset constants and width helper for the PRN CDR delay-line controller
package prn_cdr_pkg;
  typedef enum logic [1:0] {CMD_HOLD, CMD_RIGHT, CMD_LEFT} shift_cmd_t;
  localparam int RST_GAP = 0;
  localparam int RST_QUIET = 0;
  localparam logic RST_LOCKED = 1'b0;
  function automatic int clog2_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dlc_tap_ctrl.sv
// dlc_tap_ctrl: shift command decode, tap pointer, move rate limiter and lock counter (DLC_LOCK_DET_EN)
module dlc_tap_ctrl import prn_cdr_pkg::*; #(
  parameter int DEPTH    = 16,
  parameter int INIT_TAP = 8,
  parameter int STEP_GAP = 4,
  parameter int LOCK_CNT = 32,
  parameter int TAP_W    = clog2_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_right,
  input  logic             shift_left,
  output logic [TAP_W-1:0] tap,
  output logic             at_max,
  output logic             at_min,
  output logic             locked
);
  localparam int GAP_W = clog2_w(STEP_GAP + 1);
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(DEPTH - 1);
  localparam logic [TAP_W-1:0] TAP_RST = TAP_W'(INIT_TAP);
  if (DEPTH < 2 || INIT_TAP < 0 || INIT_TAP >= DEPTH || STEP_GAP < 0 || LOCK_CNT < 1)
    $error("dlc_tap_ctrl: illegal parameter set");
  shift_cmd_t cmd;
  logic move;
  logic [GAP_W-1:0] gap;
  assign at_max = tap == TAP_MAX;
  assign at_min = tap == '0;
  // conflicting requests collapse to HOLD; a move needs a quiet gap and headroom
  always_comb begin
    cmd = (shift_right & ~shift_left) ? CMD_RIGHT : (shift_left & ~shift_right) ? CMD_LEFT : CMD_HOLD;
    move = (gap == '0) && ((cmd == CMD_RIGHT && !at_max) || (cmd == CMD_LEFT && !at_min));
  end
  // tap steps once per accepted move, then the gap counter blocks further moves
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tap <= TAP_RST;
      gap <= GAP_W'(RST_GAP);
    end else if (move) begin
      tap <= (cmd == CMD_RIGHT) ? tap + 1'b1 : tap - 1'b1;
      gap <= GAP_W'(STEP_GAP);
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
`ifdef DLC_LOCK_DET_EN
  localparam int QW = clog2_w(LOCK_CNT + 1);
  logic [QW-1:0] quiet;
  // counts cycles since the last accepted move, saturating at the lock threshold
  always_ff @(posedge clk or posedge rst)
    if (rst) quiet <= QW'(RST_QUIET);
    else if (move) quiet <= '0;
    else if (quiet != QW'(LOCK_CNT)) quiet <= quiet + 1'b1;
  assign locked = quiet == QW'(LOCK_CNT);
`else
  assign locked = RST_LOCKED;
`endif
endmodule

// File: rtl/prn_delay_line_ctrl.sv
// prn_delay_line_ctrl: tapped sample delay line steered by the phase detector; lock detect via DLC_LOCK_DET_EN
module prn_delay_line_ctrl import prn_cdr_pkg::*; #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 16,
  parameter int INIT_TAP = 8,
  parameter int STEP_GAP = 4,
  parameter int LOCK_CNT = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      shift_right,
  input  logic                      shift_left,
  output logic [WIDTH-1:0]          dout,
  output logic [clog2_w(DEPTH)-1:0] tap,
  output logic                      at_max,
  output logic                      at_min,
  output logic                      locked
);
  logic [WIDTH-1:0] stage [DEPTH];
  dlc_tap_ctrl #(
    .DEPTH(DEPTH), .INIT_TAP(INIT_TAP), .STEP_GAP(STEP_GAP), .LOCK_CNT(LOCK_CNT)
  ) u_tap_ctrl (
    .clk(clk), .rst(rst), .shift_right(shift_right), .shift_left(shift_left),
    .tap(tap), .at_max(at_max), .at_min(at_min), .locked(locked)
  );
  // sample shift register with a registered tap-selected output
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      dout <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      dout <= stage[tap];
    end
endmodule

// File: tb/tb_prn_delay_line_ctrl.sv
// tb_prn_delay_line_ctrl: scoreboard bench for the delay-line controller (DEPTH=16, INIT_TAP=8, STEP_GAP=4)
module tb_prn_delay_line_ctrl;
  logic clk = 1'b0, rst = 1'b1, din = 1'b0, shift_right = 1'b0, shift_left = 1'b0;
  logic dout, at_max, at_min, locked;
  logic [3:0] tap;
  int checks = 0, failures = 0, cyc = 0;
  int m_tap = 8, m_gap = 0, m_quiet = 0;
  logic hist [int];
  logic [15:0] pat = 16'b0001100001100101;
  typedef struct {
    string name; int cyc; logic dout; logic [3:0] tap;
    logic amax; logic amin; logic lock; bit chk_dout;
  } exp_t;
  exp_t sb [$];
  string phase = "reset";

  prn_delay_line_ctrl #(.WIDTH(1), .DEPTH(16), .INIT_TAP(8), .STEP_GAP(4), .LOCK_CNT(32)) dut (
    .clk(clk), .rst(rst), .din(din), .shift_right(shift_right), .shift_left(shift_left),
    .dout(dout), .tap(tap), .at_max(at_max), .at_min(at_min), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input exp_t e);
    checks++;
    if ((e.chk_dout && dout !== e.dout) || tap !== e.tap || at_max !== e.amax ||
        at_min !== e.amin || locked !== e.lock) begin
      failures++;
      $display("FAIL %s cyc=%0d got tap=%0d dout=%b max=%b min=%b lock=%b want tap=%0d dout=%b max=%b min=%b lock=%b",
               e.name, e.cyc, tap, dout, at_max, at_min, locked, e.tap, e.dout, e.amax, e.amin, e.lock);
    end
  endtask

  function automatic exp_t hand(string n, int t, logic d, logic lk, bit cd);
    exp_t e;
    e.name = n; e.cyc = cyc; e.dout = d; e.tap = 4'(t);
    e.amax = (t == 15); e.amin = (t == 0); e.lock = lk; e.chk_dout = cd;
    return e;
  endfunction

  // monitor: every negedge, compare all expectations due for the preceding edge
  always @(negedge clk)
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      if (sb[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL %s stale expectation cyc=%0d now=%0d", sb[0].name, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end else compare(sb.pop_front());
    end

  task automatic model_reset();
    m_tap = 8; m_gap = 0; m_quiet = 0;
    hist.delete();
  endtask

  // drive one cycle and push the expected state after the coming edge
  task automatic step(input logic sr, input logic sl, input logic d);
    exp_t e;
    int q, idx;
    bit mv;
    shift_right = sr; shift_left = sl; din = d;
    q = cyc + 1;
    hist[q] = d;
    idx = q - 1 - m_tap;
    e.dout = hist.exists(idx) ? hist[idx] : 1'b0;
    mv = (m_gap == 0) && ((sr && !sl && m_tap < 15) || (sl && !sr && m_tap > 0));
    if (mv) begin
      m_tap = sr ? m_tap + 1 : m_tap - 1;
      m_gap = 4;
    end else if (m_gap > 0) m_gap--;
    m_quiet = mv ? 0 : (m_quiet < 32 ? m_quiet + 1 : 32);
    e.name = phase; e.cyc = q; e.tap = 4'(m_tap);
    e.amax = (m_tap == 15); e.amin = (m_tap == 0); e.chk_dout = 1'b1;
`ifdef DLC_LOCK_DET_EN
    e.lock = (m_quiet == 32);
`else
    e.lock = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    #12 compare(hand("reset_state", 8, 1'b0, 1'b0, 1'b1));
    #8 rst = 1'b0;
    phase = "idle_delay";
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, pat[15 - (i % 16)]);
    compare(hand("idle_tap8", 8, 1'b0, 1'b0, 1'b0));
    phase = "shift_right_run";
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, pat[i % 16]);
    compare(hand("sat_max", 15, 1'b0, 1'b0, 1'b0));
    phase = "both_hold";
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, pat[(i * 3) % 16]);
    compare(hand("hold_tap15", 15, 1'b0, 1'b0, 1'b0));
    phase = "shift_left_run";
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, pat[15 - (i % 16)]);
    compare(hand("sat_min", 0, 1'b0, 1'b0, 1'b0));
    phase = "min_pulse";
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    compare(hand("no_gap_after_block", 1, 1'b0, 1'b0, 1'b0));
    phase = "lock_quiet";
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, pat[i % 16]);
`ifdef DLC_LOCK_DET_EN
    compare(hand("locked_set", 1, 1'b0, 1'b1, 1'b0));
`endif
    phase = "lock_drop";
    step(1'b0, 1'b1, 1'b1);
    compare(hand("locked_drop", 0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    phase = "run_to_12";
    guard = 0;
    while (m_tap < 12 && guard < 200) begin
      step(1'b1, 1'b0, 1'b1);
      guard++;
    end
    step(1'b0, 1'b0, 1'b1);
    compare(hand("pre_reset_tap12", 12, 1'b0, 1'b0, 1'b0));
    #2;
    sb.delete();
    rst = 1'b1;
    #1 compare(hand("async_reset", 8, 1'b0, 1'b0, 1'b1));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare(hand("reset_held", 8, 1'b0, 1'b0, 1'b1));
    rst = 1'b0;
    phase = "post_reset_move";
    step(1'b1, 1'b0, 1'b1);
    phase = "post_reset_refill";
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1);
    shift_right = 1'b0; shift_left = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
